// File: rtl/alu_arbiter_if.sv
// Purpose : Bundles the requester handshakes and the ALU connection of alu_arbiter.
// Signals : req_valid/req_ready/req_op1/req_op2/req_ctrl - two request channels (packed per index)
//           rsp_valid/rsp_ready/rsp_out/rsp_eq          - one-hot response channel
//           alu_op1/alu_op2/alu_ctrl                    - registered operands to the shared ALU
//           alu_out/alu_eq                              - combinational ALU result
// Modports: slave  - the arbiter
//           master - requesters plus the ALU instance
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 1
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*DATA_WIDTH-1:0] req_op1;
  logic [2*DATA_WIDTH-1:0] req_op2;
  logic [2*CTRL_WIDTH-1:0] req_ctrl;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_out;
  logic                    rsp_eq;
  logic [DATA_WIDTH-1:0]   alu_op1;
  logic [DATA_WIDTH-1:0]   alu_op2;
  logic [CTRL_WIDTH-1:0]   alu_ctrl;
  logic [DATA_WIDTH-1:0]   alu_out;
  logic                    alu_eq;

  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready, alu_out, alu_eq,
    output req_ready, rsp_valid, rsp_out, rsp_eq, alu_op1, alu_op2, alu_ctrl
  );

  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, rsp_ready, alu_out, alu_eq,
    input  req_ready, rsp_valid, rsp_out, rsp_eq, alu_op1, alu_op2, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose : Shares one combinational ALU between the execute stage (req 0) and the
//           branch/address unit (req 1). IDLE grants one request, EXEC lets the ALU
//           settle on the registered operands, RESP holds the result until taken.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - alu_arbiter_if.slave (request, response and ALU signals)
// Config  : ALU_ARB_FIXED_PRIO_EN defined -> req 0 always wins a tie;
//           undefined (default)           -> round-robin using the last grant.
// Note    : req_ready is the only combinational output (asserted in the IDLE cycle).
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 1
) (
  input logic           clk,
  input logic           rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic                  rsp_eq_q, rsp_eq_d;
  logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [DATA_WIDTH-1:0] alu_op2_q, alu_op2_d;
  logic [CTRL_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [1:0]            req_ready_c;
  logic                  win_c;

  // Winner selection among the pending requests
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    win_c = ~bus.req_valid[0];
  end
`else
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (&bus.req_valid) win_c = ~last_grant_q;
    else                win_c = bus.req_valid[1];
  end
`endif

  // Next-state and datapath selection
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    rsp_eq_d    = rsp_eq_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_ctrl_d  = alu_ctrl_q;
    req_ready_c = 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        // rst_n gate keeps ready low while reset is held with requests pending
        if (rst_n && (|bus.req_valid)) begin
          req_ready_c = win_c ? 2'b10 : 2'b01;
          grant_d     = win_c;
          alu_op1_d   = win_c ? bus.req_op1[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_op1[DATA_WIDTH-1:0];
          alu_op2_d   = win_c ? bus.req_op2[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_op2[DATA_WIDTH-1:0];
          alu_ctrl_d  = win_c ? bus.req_ctrl[2*CTRL_WIDTH-1:CTRL_WIDTH] : bus.req_ctrl[CTRL_WIDTH-1:0];
          state_d     = EXEC;
        end
      end
      EXEC: begin
        rsp_out_d   = bus.alu_out;
        rsp_eq_d    = bus.alu_eq;
        rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[grant_q]) begin
          rsp_valid_d = 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant_d = grant_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_out_q   <= '0;
      rsp_eq_q    <= 1'b0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_ctrl_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_eq_q    <= rsp_eq_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_ctrl_q  <= alu_ctrl_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset to 1 so that req 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`endif

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_eq    = rsp_eq_q;
  assign bus.alu_op1   = alu_op1_q;
  assign bus.alu_op2   = alu_op2_q;
  assign bus.alu_ctrl  = alu_ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : Self-checking bench for alu_arbiter: directed scenarios with literal
//           expectations followed by randomized traffic compared every cycle
//           against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Simple ALU: ctrl=1 adds, ctrl=0 subtracts; eq flags equal operands
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [CW-1:0] c);
    return c[0] ? a + b : a - b;
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_op1, bus.alu_op2, bus.alu_ctrl);
  assign bus.alu_eq  = (bus.alu_op1 == bus.alu_op2);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic pick(input logic [1:0] v, input logic last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v[0] ? 1'b0 : 1'b1;
`else
    if (v == 2'b11) return ~last;
    return v[1];
`endif
  endfunction

  function automatic logic [DW-1:0] op_of(input logic [2*DW-1:0] v, input logic i);
    return i ? v[2*DW-1:DW] : v[DW-1:0];
  endfunction

  logic          m_busy;
  int            m_age;
  logic          m_win, m_last;
  logic [1:0]    m_rv;
  logic [DW-1:0] m_out, m_a1, m_a2, m_res;
  logic          m_eq, m_res_eq;
  logic [CW-1:0] m_ac;
  logic          m_pick;
  logic [1:0]    exp_ready;

  assign m_pick    = pick(bus.req_valid, m_last);
  assign exp_ready = (rst_n && !m_busy && (|bus.req_valid)) ? (m_pick ? 2'b10 : 2'b01) : 2'b00;

  // Transaction view: an accepted op is answered one cycle later with the result
  // the ALU gives for the requester's operands, held until that requester takes it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_last <= 1'b1; m_rv <= 2'b00;
      m_out <= '0; m_eq <= 1'b0; m_a1 <= '0; m_a2 <= '0; m_ac <= '0;
      m_win <= 1'b0; m_res <= '0; m_res_eq <= 1'b0;
    end else if (!m_busy) begin
      if (|bus.req_valid) begin
        m_busy   <= 1'b1;
        m_age    <= 1;
        m_win    <= m_pick;
        m_a1     <= op_of(bus.req_op1, m_pick);
        m_a2     <= op_of(bus.req_op2, m_pick);
        m_ac     <= m_pick ? bus.req_ctrl[1] : bus.req_ctrl[0];
        m_res    <= alu_fn(op_of(bus.req_op1, m_pick), op_of(bus.req_op2, m_pick),
                           m_pick ? bus.req_ctrl[1] : bus.req_ctrl[0]);
        m_res_eq <= (op_of(bus.req_op1, m_pick) == op_of(bus.req_op2, m_pick));
      end
    end else if (m_age == 1) begin
      m_age <= 2;
      m_rv  <= m_win ? 2'b10 : 2'b01;
      m_out <= m_res;
      m_eq  <= m_res_eq;
    end else if (bus.rsp_ready[m_win]) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_rv   <= 2'b00;
      m_last <= m_win;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
    chk("rsp_out",   64'(bus.rsp_out),   64'(m_out));
    chk("rsp_eq",    64'(bus.rsp_eq),    64'(m_eq));
    chk("alu_op1",   64'(bus.alu_op1),   64'(m_a1));
    chk("alu_op2",   64'(bus.alu_op2),   64'(m_a2));
    chk("alu_ctrl",  64'(bus.alu_ctrl),  64'(m_ac));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [CW-1:0] c);
    bus.req_valid[i]        = v;
    bus.req_op1[i*DW +: DW] = a;
    bus.req_op2[i*DW +: DW] = b;
    bus.req_ctrl[i*CW +: CW] = c;
  endtask

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return DW'($urandom_range(0, 15));
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    rdy;
    logic [DW-1:0] a, b;
    logic          exp_g;
    int            n;

    bus.req_valid = 2'b11;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_ctrl  = '0;
    bus.rsp_ready = 2'b00;

    // Reset held with both requests pending
    repeat (2) @(negedge clk);
    chk("t1_req_ready", 64'(bus.req_ready), 64'h0);
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("t1_alu_op1",   64'(bus.alu_op1),   64'h0);
    chk("t1_alu_op2",   64'(bus.alu_op2),   64'h0);
    step();
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    step();

    // Single op from req 0: 5 + 7
    bus.rsp_ready = 2'b11;
    set_req(0, 1'b1, 32'd5, 32'd7, 1'b1);
    @(negedge clk);
    chk("t2_req_ready", 64'(bus.req_ready), 64'h1);
    step();
    set_req(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("t2_exec_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    step();
    @(negedge clk);
    chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t2_rsp_out",   64'(bus.rsp_out),   64'd12);
    chk("t2_rsp_eq",    64'(bus.rsp_eq),    64'h0);
    step();

    // Wrap-around add from req 1
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("t4_req_ready", 64'(bus.req_ready), 64'h2);
    step();
    set_req(1, 1'b0, '0, '0, '0);
    step();
    @(negedge clk);
    chk("t4_rsp_valid", 64'(bus.rsp_valid), 64'h2);
    chk("t4_rsp_out",   64'(bus.rsp_out),   64'hFFFF_FFFE);
    chk("t4_rsp_eq",    64'(bus.rsp_eq),    64'h1);
    step();

    // Both held valid: grant order and spacing
    set_req(0, 1'b1, 32'd10, 32'd3, 1'b0);
    set_req(1, 1'b1, 32'd20, 32'd20, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (bus.req_ready == 2'b00 && n < 12) begin
        n++;
        @(negedge clk);
      end
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = k[0];
`endif
      chk("t3_grant", 64'(bus.req_ready), exp_g ? 64'h2 : 64'h1);
      if (k > 0) chk("t3_gap", 64'(n + 1), 64'd3);
      step();
      set_req(exp_g ? 1 : 0, 1'b1, rnd_val(), rnd_val(), CW'($urandom));
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    step();
    step();

    // Response held while requester 0 stalls; rsp_ready[1] is ignored
    bus.rsp_ready = 2'b10;
    set_req(0, 1'b1, 32'd100, 32'd30, 1'b0);
    @(negedge clk);
    chk("t5_req_ready0", 64'(bus.req_ready), 64'h1);
    step();
    set_req(0, 1'b0, '0, '0, '0);
    step();
    set_req(1, 1'b1, 32'd1, 32'd2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", 64'(bus.rsp_valid), 64'h1);
      chk("t5_hold_out",   64'(bus.rsp_out),   64'd70);
      chk("t5_hold_ready", 64'(bus.req_ready), 64'h0);
      step();
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    chk("t5_release_ready", 64'(bus.req_ready), 64'h0);
    step();
    @(negedge clk);
    chk("t5_req1_grant", 64'(bus.req_ready), 64'h2);
    step();
    set_req(1, 1'b0, '0, '0, '0);
    bus.rsp_ready = 2'b11;
    step();
    step();

    // Reset during EXEC drops the op
    set_req(0, 1'b1, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    chk("t6_req_ready", 64'(bus.req_ready), 64'h1);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("t6_alu_op1",   64'(bus.alu_op1),   64'h0);
    chk("t6_alu_op2",   64'(bus.alu_op2),   64'h0);
    chk("t6_rsp_out",   64'(bus.rsp_out),   64'h0);
    set_req(0, 1'b0, '0, '0, '0);
    step();
    step();
    rst_n = 1'b1;
    set_req(0, 1'b1, 32'd4, 32'd1, 1'b0);
    set_req(1, 1'b1, 32'd6, 32'd2, 1'b0);
    @(negedge clk);
    chk("t6_first_grant", 64'(bus.req_ready), 64'h1);

    // Randomized traffic; requesters hold valid+payload until accepted
    for (int c = 0; c < 3000; c++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] || rdy[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            a = rnd_val();
            b = ($urandom_range(0, 3) == 0) ? a : rnd_val();
            set_req(i, 1'b1, a, b, CW'($urandom));
          end else begin
            set_req(i, 1'b0, '0, '0, '0);
          end
        end
      end
      bus.rsp_ready = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 149) != 0);
      @(negedge clk);
    end

    rst_n = 1'b1;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
